ipif_rr_arbiter: RTL and testbench



---
 rtl/ipif_rr_arbiter_if.sv | 45 ++++
 rtl/ipif_rr_arbiter.sv | 157 +++++++++++++++
 tb/tb_ipif_rr_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ipif_rr_arbiter_if.sv
// Signal bundle between the requesters, the round-robin arbiter and the IPIF register bank.
// The arbiter takes the slave modport; the requester/bank environment takes the master modport.
interface ipif_rr_arbiter_if #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned NUM_MASTERS        = 2
);
  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned N  = NUM_MASTERS;
  localparam int unsigned BW = DW / 8;

  logic [N-1:0]    m_req;
  logic [N*AW-1:0] m_addr;
  logic [N-1:0]    m_rnw;
  logic [N*DW-1:0] m_wdata;
  logic [N*BW-1:0] m_be;
  logic [N-1:0]    m_ack;
  logic [N-1:0]    m_err;
  logic [DW-1:0]   m_rdata;

  logic            Bus2IP_CS;
  logic            Bus2IP_RNW;
  logic [AW-1:0]   Bus2IP_Addr;
  logic [DW-1:0]   Bus2IP_Data;
  logic [BW-1:0]   Bus2IP_BE;
  logic [DW-1:0]   IP2Bus_Data;
  logic            IP2Bus_RdAck;
  logic            IP2Bus_WrAck;
  logic            IP2Bus_Error;

  modport slave (
    input  m_req, m_addr, m_rnw, m_wdata, m_be,
    output m_ack, m_err, m_rdata,
    output Bus2IP_CS, Bus2IP_RNW, Bus2IP_Addr, Bus2IP_Data, Bus2IP_BE,
    input  IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
  );

  modport master (
    output m_req, m_addr, m_rnw, m_wdata, m_be,
    input  m_ack, m_err, m_rdata,
    input  Bus2IP_CS, Bus2IP_RNW, Bus2IP_Addr, Bus2IP_Data, Bus2IP_BE,
    output IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
  );
endinterface

// File: rtl/ipif_rr_arbiter.sv
// Round-robin arbiter sharing one IPIF register-bank port between NUM_MASTERS requesters,
// with a single-cycle CS strobe per access and a timeout for accesses the bank never acks.
module ipif_rr_arbiter #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned NUM_MASTERS        = 2,
  parameter int unsigned TIMEOUT_CYCLES     = 16
) (
  input logic              Bus2IP_Clk,
  input logic              Bus2IP_Resetn,
  ipif_rr_arbiter_if.slave bus
);
  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned N  = NUM_MASTERS;
  localparam int unsigned BW = DW / 8;
  localparam int unsigned GW = $clog2(N);
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    r_state;
  logic [GW-1:0] r_last_grant;
  logic [GW-1:0] r_grant;
  logic [CW-1:0] r_cnt;
  logic          r_cs;
  logic          r_rnw;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic [BW-1:0] r_be;
  logic [N-1:0]  r_m_ack;
  logic [N-1:0]  r_m_err;
  logic [DW-1:0] r_m_rdata;

  logic          w_found;
  logic [GW-1:0] w_next;
  logic [GW-1:0] w_idx;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;
  logic [BW-1:0] w_sel_be;
  logic          w_sel_rnw;
  logic [N-1:0]  w_grant_oh;
  logic          w_bus_ack;
  logic [CW-1:0] w_cnt_inc;
  logic          w_timeout;

  // Search starts just after the last winner and wraps, so the first hit is the fair choice.
  always_comb begin
    w_found = 1'b0;
    w_next  = '0;
    w_idx   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_idx = GW'((32'(r_last_grant) + k) % N);
      if (!w_found && bus.m_req[w_idx]) begin
        w_found = 1'b1;
        w_next  = w_idx;
      end
    end
  end

  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_be    = '0;
    w_sel_rnw   = 1'b1;
    for (int unsigned i = 0; i < N; i++) begin
      if (w_next == GW'(i)) begin
        w_sel_addr  = bus.m_addr[i*AW +: AW];
        w_sel_wdata = bus.m_wdata[i*DW +: DW];
        w_sel_be    = bus.m_be[i*BW +: BW];
        w_sel_rnw   = bus.m_rnw[i];
      end
    end
  end

  always_comb begin
    w_grant_oh = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_grant_oh[i] = (r_grant == GW'(i));
    end
  end

  assign w_bus_ack = bus.IP2Bus_RdAck | bus.IP2Bus_WrAck;
  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_timeout = (w_cnt_inc == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      r_state      <= S_IDLE;
      r_last_grant <= GW'(N - 1);
      r_grant      <= '0;
      r_cnt        <= '0;
      r_cs         <= 1'b0;
      r_rnw        <= 1'b1;
      r_addr       <= '0;
      r_data       <= '0;
      r_be         <= '0;
      r_m_ack      <= '0;
      r_m_err      <= '0;
      r_m_rdata    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant      <= w_next;
            r_last_grant <= w_next;
            r_addr       <= w_sel_addr;
            r_data       <= w_sel_wdata;
            r_be         <= w_sel_be;
            r_rnw        <= w_sel_rnw;
            r_cs         <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cs    <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Completion is registered here so m_ack/m_err/m_rdata are valid throughout DONE.
          if (w_bus_ack) begin
            r_m_rdata <= r_rnw ? bus.IP2Bus_Data : '0;
            r_m_err   <= w_grant_oh & {N{bus.IP2Bus_Error}};
            r_m_ack   <= w_grant_oh;
            r_state   <= S_DONE;
          end else if (w_timeout) begin
            r_m_rdata <= '0;
            r_m_err   <= w_grant_oh;
            r_m_ack   <= w_grant_oh;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_DONE: begin
          r_m_ack <= '0;
          r_m_err <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.m_ack       = r_m_ack;
  assign bus.m_err       = r_m_err;
  assign bus.m_rdata     = r_m_rdata;
  assign bus.Bus2IP_CS   = r_cs;
  assign bus.Bus2IP_RNW  = r_rnw;
  assign bus.Bus2IP_Addr = r_addr;
  assign bus.Bus2IP_Data = r_data;
  assign bus.Bus2IP_BE   = r_be;
endmodule

// File: tb/tb_ipif_rr_arbiter.sv
// Directed bench for ipif_rr_arbiter: a vector table of single accesses against a small
// register-bank model, plus hand sequences for grant-time latching, mid-access reset and fairness.
module tb_ipif_rr_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ipif_rr_arbiter_if #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(32),
    .NUM_MASTERS(2)
  ) bus ();

  ipif_rr_arbiter #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(32),
    .NUM_MASTERS(2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .Bus2IP_Clk(clk),
    .Bus2IP_Resetn(rst_n),
    .bus(bus.slave)
  );

  // Bank: 0x0 write-only, 0x4 read/write, 0x8 read-only (0xA5), 0xC acks with error.
  logic [31:0] wo_reg;
  logic [31:0] rw_reg;
  always_ff @(posedge clk) begin
    bus.IP2Bus_RdAck <= 1'b0;
    bus.IP2Bus_WrAck <= 1'b0;
    bus.IP2Bus_Error <= 1'b0;
    bus.IP2Bus_Data  <= 32'h0;
    if (bus.Bus2IP_CS) begin
      case (bus.Bus2IP_Addr)
        32'h0: if (!bus.Bus2IP_RNW) begin
          bus.IP2Bus_WrAck <= 1'b1;
          for (int b = 0; b < 4; b++)
            if (bus.Bus2IP_BE[b]) wo_reg[8*b +: 8] <= bus.Bus2IP_Data[8*b +: 8];
        end
        32'h4: if (bus.Bus2IP_RNW) begin
          bus.IP2Bus_RdAck <= 1'b1;
          bus.IP2Bus_Data  <= rw_reg;
        end else begin
          bus.IP2Bus_WrAck <= 1'b1;
          for (int b = 0; b < 4; b++)
            if (bus.Bus2IP_BE[b]) rw_reg[8*b +: 8] <= bus.Bus2IP_Data[8*b +: 8];
        end
        32'h8: if (bus.Bus2IP_RNW) begin
          bus.IP2Bus_RdAck <= 1'b1;
          bus.IP2Bus_Data  <= 32'h0000_00A5;
        end
        32'hC: begin
          bus.IP2Bus_RdAck <= bus.Bus2IP_RNW;
          bus.IP2Bus_WrAck <= !bus.Bus2IP_RNW;
          bus.IP2Bus_Error <= 1'b1;
          bus.IP2Bus_Data  <= 32'hBAD0_BAD0;
        end
        default: ;
      endcase
    end
  end

  int          cs_total = 0;
  logic [31:0] cs_addr, cs_data;
  logic        cs_rnw;
  logic [3:0]  cs_be;
  always @(negedge clk) begin
    if (bus.Bus2IP_CS) begin
      cs_total = cs_total + 1;
      cs_addr  = bus.Bus2IP_Addr;
      cs_data  = bus.Bus2IP_Data;
      cs_rnw   = bus.Bus2IP_RNW;
      cs_be    = bus.Bus2IP_BE;
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] rnw,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [3:0] be0, input logic [3:0] be1);
    bus.m_req   = req;
    bus.m_rnw   = rnw;
    bus.m_addr  = {a1, a0};
    bus.m_wdata = {d1, d0};
    bus.m_be    = {be1, be0};
  endtask

  task automatic wait_ack(output int cyc, output logic [1:0] ack,
                          output logic [1:0] err, output logic [31:0] rd);
    cyc = 0;
    ack = 2'b00;
    while (ack == 2'b00 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      ack = bus.m_ack;
    end
    err = bus.m_err;
    rd  = bus.m_rdata;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},   {30'h0, bus.m_ack}, 32'h0);
    check({tag, "_err"},   {30'h0, bus.m_err}, 32'h0);
    check({tag, "_rdata"}, bus.m_rdata, 32'h0);
    check({tag, "_cs"},    {31'h0, bus.Bus2IP_CS}, 32'h0);
    check({tag, "_rnw"},   {31'h0, bus.Bus2IP_RNW}, 32'h1);
    check({tag, "_addr"},  bus.Bus2IP_Addr, 32'h0);
    check({tag, "_data"},  bus.Bus2IP_Data, 32'h0);
    check({tag, "_be"},    {28'h0, bus.Bus2IP_BE}, 32'h0);
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  rnw;
    logic [31:0] a0, a1, d0, d1;
    logic [3:0]  be0, be1;
    logic [1:0]  e_ack;
    logic        e_err;
    logic [31:0] e_rd;
    int          e_cyc;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int          cyc, cs0, g, n;
    logic [1:0]  ack, err;
    logic [31:0] rd;
    logic [1:0]  f_ack[4];
    int          f_cyc[4];
    logic [31:0] f_rd[4];

    //          req    rnw    a0     a1     d0            d1            be0   be1   ack    err   rdata          cyc
    vecs[0]  = '{2'b01, 2'b00, 32'h0, 32'h0, 32'hCAFEF00D, 32'h0,        4'hF, 4'h0, 2'b01, 1'b0, 32'h0,         3};
    vecs[1]  = '{2'b10, 2'b00, 32'h0, 32'h4, 32'h0,        32'h12345678, 4'h0, 4'hF, 2'b10, 1'b0, 32'h0,         3};
    vecs[2]  = '{2'b10, 2'b10, 32'h0, 32'h4, 32'h0,        32'h0,        4'h0, 4'hF, 2'b10, 1'b0, 32'h12345678,  3};
    vecs[3]  = '{2'b01, 2'b01, 32'h0, 32'h0, 32'h0,        32'h0,        4'hF, 4'h0, 2'b01, 1'b1, 32'h0,         18};
    vecs[4]  = '{2'b01, 2'b00, 32'h4, 32'h0, 32'hFFFFFFFF, 32'h0,        4'h3, 4'h0, 2'b01, 1'b0, 32'h0,         3};
    vecs[5]  = '{2'b10, 2'b10, 32'h0, 32'h4, 32'h0,        32'h0,        4'h0, 4'hF, 2'b10, 1'b0, 32'h1234FFFF,  3};
    vecs[6]  = '{2'b10, 2'b10, 32'h0, 32'hC, 32'h0,        32'h0,        4'h0, 4'hF, 2'b10, 1'b1, 32'hBAD0BAD0,  3};
    vecs[7]  = '{2'b10, 2'b00, 32'h0, 32'h8, 32'h0,        32'h99999999, 4'h0, 4'hF, 2'b10, 1'b1, 32'h0,         18};
    vecs[8]  = '{2'b11, 2'b11, 32'h8, 32'h4, 32'h0,        32'h0,        4'hF, 4'hF, 2'b01, 1'b0, 32'h000000A5,  3};
    vecs[9]  = '{2'b11, 2'b11, 32'h8, 32'h4, 32'h0,        32'h0,        4'hF, 4'hF, 2'b10, 1'b0, 32'h1234FFFF,  3};
    vecs[10] = '{2'b01, 2'b00, 32'hC, 32'h0, 32'h00000001, 32'h0,        4'hF, 4'h0, 2'b01, 1'b1, 32'h0,         3};

    drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].req, vecs[i].rnw, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1,
            vecs[i].be0, vecs[i].be1);
      cs0 = cs_total;
      wait_ack(cyc, ack, err, rd);
      check($sformatf("v%0d_lat", i), cyc, vecs[i].e_cyc);
      check($sformatf("v%0d_ack", i), {30'h0, ack}, {30'h0, vecs[i].e_ack});
      check($sformatf("v%0d_err", i), {30'h0, err},
            {30'h0, vecs[i].e_err ? vecs[i].e_ack : 2'b00});
      check($sformatf("v%0d_rdata", i), rd, vecs[i].e_rd);
      @(negedge clk);
      bus.m_req = 2'b00;
      g = vecs[i].e_ack[1] ? 1 : 0;
      check($sformatf("v%0d_cs_pulses", i), cs_total - cs0, 1);
      check($sformatf("v%0d_cs_addr", i), cs_addr, g ? vecs[i].a1 : vecs[i].a0);
      check($sformatf("v%0d_cs_rnw", i), {31'h0, cs_rnw}, {31'h0, vecs[i].rnw[g]});
      if (!vecs[i].rnw[g]) begin
        check($sformatf("v%0d_cs_data", i), cs_data, g ? vecs[i].d1 : vecs[i].d0);
        check($sformatf("v%0d_cs_be", i), {28'h0, cs_be}, {28'h0, g ? vecs[i].be1 : vecs[i].be0});
      end
      @(posedge clk); #1;
      check($sformatf("v%0d_ack_single", i), {30'h0, bus.m_ack}, 32'h0);
      if (i == 0) check("wo_reg0", wo_reg, 32'hCAFEF00D);
    end

    // Fields changed after grant must not reach the bank.
    @(negedge clk);
    drive(2'b01, 2'b00, 32'h4, 32'h0, 32'h11111111, 32'h0, 4'hF, 4'h0);
    @(posedge clk); #1;
    check("fc_cs_high", {31'h0, bus.Bus2IP_CS}, 32'h1);
    @(negedge clk);
    drive(2'b01, 2'b00, 32'h0, 32'h0, 32'h22222222, 32'h0, 4'h0, 4'h0);
    wait_ack(cyc, ack, err, rd);
    check("fc_lat", cyc, 2);
    check("fc_ack", {30'h0, ack}, 32'h1);
    check("fc_addr_held", bus.Bus2IP_Addr, 32'h4);
    check("fc_data_held", bus.Bus2IP_Data, 32'h11111111);
    check("fc_be_held", {28'h0, bus.Bus2IP_BE}, 32'hF);
    @(negedge clk);
    bus.m_req = 2'b00;
    @(negedge clk);
    drive(2'b10, 2'b10, 32'h0, 32'h4, 32'h0, 32'h0, 4'h0, 4'hF);
    wait_ack(cyc, ack, err, rd);
    check("fc_readback", rd, 32'h11111111);
    check("fc_wo_untouched", wo_reg, 32'hCAFEF00D);
    @(negedge clk);
    bus.m_req = 2'b00;
    @(negedge clk);

    // Reset during WAIT of a never-acked write by master 0.
    drive(2'b01, 2'b00, 32'h8, 32'h0, 32'h55AA55AA, 32'h0, 4'hF, 4'h0);
    repeat (6) @(posedge clk);
    #2;
    check("mr_in_flight_rnw", {31'h0, bus.Bus2IP_RNW}, 32'h0);
    rst_n = 1'b0;
    bus.m_req = 2'b11;
    bus.m_rnw = 2'b11;
    bus.m_addr = {32'h8, 32'h4};
    #1;
    check_reset_outputs("mr");
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("mr_no_ack", {30'h0, bus.m_ack}, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_ack(cyc, ack, err, rd);
    check("mr_lat", cyc, 3);
    check("mr_m0_first", {30'h0, ack}, 32'h1);
    check("mr_rdata", rd, 32'h11111111);
    @(negedge clk);
    bus.m_req = 2'b00;
    @(negedge clk);

    // Fairness straight after reset: both held for four transactions.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(2'b11, 2'b11, 32'h8, 32'h4, 32'h0, 32'h0, 4'hF, 4'hF);
    n = 0;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      if (bus.m_ack != 2'b00) begin
        if (n < 4) begin
          f_ack[n] = bus.m_ack;
          f_cyc[n] = c;
          f_rd[n]  = bus.m_rdata;
        end
        n++;
      end
    end
    @(negedge clk);
    bus.m_req = 2'b00;
    check("rr_count", n, 4);
    for (int k = 0; k < 4; k++) begin
      if (k < n) begin
        check($sformatf("rr%0d_ack", k), {30'h0, f_ack[k]}, (k % 2 == 0) ? 32'h1 : 32'h2);
        check($sformatf("rr%0d_cyc", k), f_cyc[k], 3 + 4 * k);
        check($sformatf("rr%0d_rdata", k), f_rd[k], (k % 2 == 0) ? 32'h000000A5 : 32'h11111111);
      end
    end
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
